// File: rtl/cdc_host_engine.sv
// -----------------------------------------------------------------------------
// cdc_host_engine
//   LC8951-style CD host-interface register block for the Neo CD path, with a
//   byte-transfer engine (DTTRG start, DBC count-down, DAC count-up, DTEI at
//   end) and a small sector-header FIFO so several decoded sectors can queue
//   before the system ROM reads them.
//
// Ports
//   CLK, nRESET        clock (rising edge) / async active-low reset
//   nWR, nRD, RS, DIN  68k register window; falling strobe edge = one access
//   DOUT               read data, registered on the nRD falling edge
//   MSF_M/S/F          header of the sector being latched
//   MSF_LATCH          rising edge pushes {M,S,F} into the header FIFO
//   SECTOR_READY       rising edge sets DECI
//   XFER_REQ/ADDR/ACK  byte-transfer handshake towards the buffer fabric
//   HDR_OVF            sticky header-FIFO overflow
//   CDC_nIRQ           registered, active-low interrupt
//
// Parameters: HDR_DEPTH (power of 2, >=2), DBC_W (9..16), ADDR_W (9..16).
// -----------------------------------------------------------------------------
module cdc_host_engine #(
    parameter int HDR_DEPTH = 4,
    parameter int DBC_W     = 12,
    parameter int ADDR_W    = 16
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              nWR,
    input  logic              nRD,
    input  logic              RS,
    input  logic [7:0]        DIN,
    output logic [7:0]        DOUT,
    input  logic [7:0]        MSF_M,
    input  logic [7:0]        MSF_S,
    input  logic [7:0]        MSF_F,
    input  logic              MSF_LATCH,
    input  logic              SECTOR_READY,
    output logic              XFER_REQ,
    output logic [ADDR_W-1:0] XFER_ADDR,
    input  logic              XFER_ACK,
    output logic              HDR_OVF,
    output logic              CDC_nIRQ
);

    localparam int               PTR_W    = $clog2(HDR_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(HDR_DEPTH);
    // There is no command channel, so CMDI is permanently clear.
    localparam logic             CMDI     = 1'b0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t            state_q;
    logic              nwr_q, nrd_q, latch_q, srdy_q;
    logic [3:0]        ar_q;
    logic [7:0]        dout_q, ifctrl_q, ctrl0_q, ctrl1_q;
    logic [15:0]       wa_q;
    logic [DBC_W-1:0]  dbc_q;
    logic [ADDR_W-1:0] dac_q;
    logic              xreq_q, dtei_q, deci_q, ovf_q, nirq_q;

    logic [7:0]        fifo_m [HDR_DEPTH];
    logic [7:0]        fifo_s [HDR_DEPTH];
    logic [7:0]        fifo_f [HDR_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic wr_fire, rd_fire, reg_wr, reg_rd, busy;
    logic fifo_empty, fifo_full, push, pop, srdy_rise;
    logic [7:0] dbch, reg_rd_data, rd_data;

    // A write edge takes precedence when both strobes fall together.
    assign wr_fire    = nwr_q & ~nWR;
    assign rd_fire    = ~wr_fire & nrd_q & ~nRD;
    assign reg_wr     = wr_fire & RS;
    assign reg_rd     = rd_fire & RS;
    assign busy       = (state_q != S_IDLE);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign push       = MSF_LATCH & ~latch_q;
    assign pop        = reg_rd & (ar_q == 4'd15) & ~fifo_empty;
    assign srdy_rise  = SECTOR_READY & ~srdy_q;
    assign dbch       = {{4{dtei_q}}, 4'h0} | 8'(dbc_q >> 8);

    always_comb begin
        reg_rd_data = 8'h00;
        case (ar_q)
            4'd1:  reg_rd_data = {~CMDI, ~dtei_q, ~deci_q, 1'b1, ~busy, 1'b1, ~busy, 1'b1};
            4'd2:  reg_rd_data = dbc_q[7:0];
            4'd3:  reg_rd_data = dbch;
            4'd4:  reg_rd_data = fifo_empty ? 8'h00 : fifo_m[rd_ptr_q];
            4'd5:  reg_rd_data = fifo_empty ? 8'h00 : fifo_s[rd_ptr_q];
            4'd6:  reg_rd_data = fifo_empty ? 8'h00 : fifo_f[rd_ptr_q];
            4'd7:  reg_rd_data = 8'h01;
            4'd8:  reg_rd_data = 8'h04;
            4'd10: reg_rd_data = wa_q[7:0];
            4'd11: reg_rd_data = wa_q[15:8];
            4'd12: reg_rd_data = 8'h80;
            4'd13: reg_rd_data = {ovf_q, 7'h0};
            4'd15: reg_rd_data = {fifo_empty, 7'h0};
            default: reg_rd_data = 8'h00;
        endcase
        rd_data = RS ? reg_rd_data : {4'h0, ar_q};
    end

    // Host side: strobe edge detect, AR, read data, config registers, DECI, IRQ.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            nwr_q    <= 1'b1;
            nrd_q    <= 1'b1;
            latch_q  <= 1'b0;
            srdy_q   <= 1'b0;
            ar_q     <= 4'd0;
            dout_q   <= 8'h00;
            ifctrl_q <= 8'h00;
            ctrl0_q  <= 8'h00;
            ctrl1_q  <= 8'h00;
            wa_q     <= 16'h0000;
            deci_q   <= 1'b0;
            nirq_q   <= 1'b1;
        end else begin
            nwr_q   <= nWR;
            nrd_q   <= nRD;
            latch_q <= MSF_LATCH;
            srdy_q  <= SECTOR_READY;

            // AR=0 is a parking slot: data accesses there never advance it.
            if (wr_fire && !RS)
                ar_q <= DIN[3:0];
            else if ((wr_fire || rd_fire) && RS && ar_q != 4'd0)
                ar_q <= ar_q + 4'd1;

            if (rd_fire)
                dout_q <= rd_data;

            if (reg_wr) begin
                case (ar_q)
                    4'd1:  ifctrl_q   <= DIN;
                    4'd8:  wa_q[7:0]  <= DIN;
                    4'd9:  wa_q[15:8] <= DIN;
                    4'd10: ctrl0_q    <= DIN;
                    4'd11: ctrl1_q    <= DIN;
                    default: ;
                endcase
            end

            // Set wins over the STAT3 read clear.
            if (srdy_rise)
                deci_q <= 1'b1;
            else if (reg_rd && ar_q == 4'd15)
                deci_q <= 1'b0;

            nirq_q <= ~|{CMDI & ifctrl_q[7], dtei_q & ifctrl_q[6], deci_q & ifctrl_q[5]};
        end
    end

    // Transfer engine. DBC/DAC are only writable while idle.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
            dbc_q   <= '0;
            dac_q   <= '0;
            xreq_q  <= 1'b0;
            dtei_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (reg_wr) begin
                        case (ar_q)
                            4'd2: dbc_q[7:0]        <= DIN;
                            4'd3: dbc_q[DBC_W-1:8]  <= DIN[DBC_W-9:0];
                            4'd4: dac_q[7:0]        <= DIN;
                            4'd5: dac_q[ADDR_W-1:8] <= DIN[ADDR_W-9:0];
                            4'd6: if (ifctrl_q[1]) begin
                                      state_q <= S_REQ;
                                      xreq_q  <= 1'b1;
                                  end
                            default: ;
                        endcase
                    end
                end
                S_REQ: begin
                    if (XFER_ACK) begin
                        dac_q <= dac_q + ADDR_W'(1);
                        // DBC counts bytes remaining minus one; the byte acked
                        // at DBC==0 is the last and leaves DBC at all ones.
                        if (dbc_q == '0) begin
                            dbc_q   <= '1;
                            xreq_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            dbc_q <= dbc_q - DBC_W'(1);
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // Completion beats a same-cycle DTACK.
            if (state_q == S_DONE)
                dtei_q <= 1'b1;
            else if (reg_wr && ar_q == 4'd7)
                dtei_q <= 1'b0;
        end
    end

    // Header FIFO control. A push into a full FIFO drops the oldest entry;
    // a pop in the same cycle frees the slot first, so nothing is lost then.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (pop || (push && fifo_full))
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (push && !pop && fifo_full)
                ovf_q <= 1'b1;
            if (push && !pop && !fifo_full)
                cnt_q <= cnt_q + CNT_W'(1);
            else if (pop && !push)
                cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_m[wr_ptr_q] <= MSF_M;
            fifo_s[wr_ptr_q] <= MSF_S;
            fifo_f[wr_ptr_q] <= MSF_F;
        end
    end

    // Write-only / reserved control bits with no function in this block.
    logic unused_ok;
    assign unused_ok = ^{ifctrl_q[4:2], ifctrl_q[0], ctrl0_q, ctrl1_q};

    assign DOUT      = dout_q;
    assign XFER_REQ  = xreq_q;
    assign XFER_ADDR = dac_q;
    assign HDR_OVF   = ovf_q;
    assign CDC_nIRQ  = nirq_q;

endmodule

// File: tb/tb_cdc_host_engine.sv
module tb_cdc_host_engine;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        nWR = 1'b1, nRD = 1'b1, RS = 1'b0;
    logic [7:0]  DIN = 8'h00;
    logic [7:0]  DOUT;
    logic [7:0]  MSF_M = 8'h00, MSF_S = 8'h00, MSF_F = 8'h00;
    logic        MSF_LATCH = 1'b0, SECTOR_READY = 1'b0, XFER_ACK = 1'b0;
    logic        XFER_REQ, HDR_OVF, CDC_nIRQ;
    logic [15:0] XFER_ADDR;

    cdc_host_engine #(.HDR_DEPTH(DEPTH), .DBC_W(12), .ADDR_W(16)) dut (
        .CLK(CLK), .nRESET(nRESET), .nWR(nWR), .nRD(nRD), .RS(RS), .DIN(DIN),
        .DOUT(DOUT), .MSF_M(MSF_M), .MSF_S(MSF_S), .MSF_F(MSF_F),
        .MSF_LATCH(MSF_LATCH), .SECTOR_READY(SECTOR_READY), .XFER_REQ(XFER_REQ),
        .XFER_ADDR(XFER_ADDR), .XFER_ACK(XFER_ACK), .HDR_OVF(HDR_OVF),
        .CDC_nIRQ(CDC_nIRQ)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // All driving happens #1 after a rising edge; sampling likewise.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic hwr(input logic rs, input logic [7:0] d);
        RS = rs; DIN = d; nWR = 1'b0;
        tick(); tick();
        nWR = 1'b1;
        tick();
    endtask

    task automatic hrd(input logic rs, output logic [7:0] d);
        RS = rs; nRD = 1'b0;
        tick();
        d = DOUT;
        tick();
        nRD = 1'b1;
        tick();
    endtask

    task automatic setreg(input logic [3:0] a, input logic [7:0] d);
        hwr(1'b0, {4'h0, a});
        hwr(1'b1, d);
    endtask

    task automatic getreg(input logic [3:0] a, output logic [7:0] d);
        hwr(1'b0, {4'h0, a});
        hrd(1'b1, d);
    endtask

    task automatic push_hdr(input logic [7:0] m, input logic [7:0] s, input logic [7:0] f);
        MSF_M = m; MSF_S = s; MSF_F = f; MSF_LATCH = 1'b1;
        tick();
        MSF_LATCH = 1'b0;
        tick();
    endtask

    task automatic start_xfer(input int n, input logic [15:0] a0, input logic [7:0] ifc);
        logic [15:0] nn;
        nn = 16'(n);
        setreg(4'd1, ifc);
        setreg(4'd2, nn[7:0]);
        setreg(4'd3, nn[15:8]);
        setreg(4'd4, a0[7:0]);
        setreg(4'd5, a0[15:8]);
        setreg(4'd6, 8'h00);
    endtask

    // Acks every request; the model expects addresses a0, a0+1, ... mod 2^16.
    task automatic run_xfer(input int nexp, input logic [15:0] a0, input bit mid_trg);
        int got, guard, gap;
        logic [15:0] ea;
        logic [7:0] d;
        got = 0; guard = 0;
        while (!XFER_REQ && guard < 8) begin tick(); guard++; end
        if (!XFER_REQ) chk("xfer_start", 32'(XFER_REQ), 32'd1);
        guard = 0;
        while (XFER_REQ && guard < 400) begin
            ea = a0 + 16'(got);
            chk($sformatf("xfer_addr[%0d]", got), 32'(XFER_ADDR), 32'(ea));
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
            XFER_ACK = 1'b1;
            tick();
            XFER_ACK = 1'b0;
            got++;
            if (mid_trg && got == 1) begin
                getreg(4'd1, d);
                chk("ifstat_busy", 32'(d), 32'h0F5);
                setreg(4'd6, 8'h00);
            end
            guard++;
        end
        chk("xfer_count", 32'(got), 32'(nexp));
    endtask

    typedef struct packed {
        logic       wr;
        logic       rs;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[$];

    task automatic addv(input logic wr, input logic rs, input logic [7:0] din, input logic [7:0] exp);
        vec_t v;
        v.wr = wr; v.rs = rs; v.din = din; v.exp = exp;
        vt.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d;
        logic [7:0]  m, s, f;
        logic [15:0] a0;
        logic [23:0] q[$];
        logic [7:0]  expb;
        bit          m_ovf;
        int          n, op;

        // ---------------- reset state
        tick(); tick();
        chk("rst_nirq", 32'(CDC_nIRQ), 32'd1);
        chk("rst_xreq", 32'(XFER_REQ), 32'd0);
        chk("rst_dout", 32'(DOUT), 32'd0);
        chk("rst_ovf", 32'(HDR_OVF), 32'd0);
        chk("rst_xaddr", 32'(XFER_ADDR), 32'd0);
        nRESET = 1'b1;
        tick();

        // ---------------- register map table
        addv(0, 0, 8'h00, 8'h00);
        addv(1, 0, 8'h01, 8'h00);
        addv(0, 1, 8'h00, 8'hFF);   // IFSTAT
        addv(0, 1, 8'h00, 8'h00);   // DBCL
        addv(0, 1, 8'h00, 8'h00);   // DBCH
        addv(0, 1, 8'h00, 8'h00);   // M
        addv(0, 1, 8'h00, 8'h00);   // S
        addv(0, 1, 8'h00, 8'h00);   // F
        addv(0, 1, 8'h00, 8'h01);   // mode
        addv(0, 1, 8'h00, 8'h04);
        addv(0, 1, 8'h00, 8'h00);
        addv(0, 1, 8'h00, 8'h00);   // WA lo
        addv(0, 1, 8'h00, 8'h00);   // WA hi
        addv(0, 1, 8'h00, 8'h80);
        addv(0, 1, 8'h00, 8'h00);   // STAT1
        addv(0, 1, 8'h00, 8'h00);
        addv(0, 1, 8'h00, 8'h80);   // STAT3, empty FIFO
        addv(0, 0, 8'h00, 8'h00);   // AR wrapped to 0
        addv(1, 0, 8'h08, 8'h00);
        addv(1, 1, 8'h5A, 8'h00);
        addv(1, 1, 8'hC3, 8'h00);
        addv(0, 1, 8'h00, 8'h5A);
        addv(0, 1, 8'h00, 8'hC3);
        addv(0, 0, 8'h00, 8'h0C);
        addv(1, 0, 8'h02, 8'h00);
        addv(1, 1, 8'h34, 8'h00);
        addv(1, 1, 8'h0A, 8'h00);
        addv(1, 0, 8'h02, 8'h00);
        addv(0, 1, 8'h00, 8'h34);
        addv(0, 1, 8'h00, 8'h0A);
        addv(1, 0, 8'h00, 8'h00);
        addv(1, 1, 8'h77, 8'h00);   // AR0 write ignored, no increment
        addv(0, 0, 8'h00, 8'h00);
        addv(1, 0, 8'h0A, 8'h00);
        addv(1, 1, 8'hFF, 8'h00);   // CTRL0
        addv(0, 0, 8'h00, 8'h0B);
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].wr) hwr(vt[i].rs, vt[i].din);
            else begin
                hrd(vt[i].rs, d);
                chk($sformatf("vec%0d", i), 32'(d), 32'(vt[i].exp));
            end
        end

        // ---------------- directed transfer with a second DTTRG mid-way
        start_xfer(3, 16'h0100, 8'h42);
        run_xfer(4, 16'h0100, 1'b1);
        tick(); tick(); tick();
        chk("done_nirq", 32'(CDC_nIRQ), 32'd0);
        getreg(4'd3, d);
        chk("done_dbch", 32'(d), 32'h0FF);
        getreg(4'd1, d);
        chk("done_ifstat", 32'(d), 32'h0BF);
        setreg(4'd7, 8'h00);
        chk("dtack_nirq", 32'(CDC_nIRQ), 32'd1);
        getreg(4'd1, d);
        chk("dtack_ifstat", 32'(d), 32'h0FF);

        // ---------------- DTTRG with DOUTEN=0
        setreg(4'd1, 8'h40);
        setreg(4'd2, 8'h02);
        setreg(4'd6, 8'h00);
        repeat (4) tick();
        chk("nodouten_xreq", 32'(XFER_REQ), 32'd0);

        // ---------------- random transfers vs address model
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(0, 20);
            if ($urandom_range(0, 2) == 0) a0 = 16'hFFFF - 16'($urandom_range(0, 5));
            else a0 = 16'($urandom);
            start_xfer(n, a0, 8'h42);
            run_xfer(n + 1, a0, 1'b0);
            tick(); tick(); tick();
            chk("rnd_nirq", 32'(CDC_nIRQ), 32'd0);
            getreg(4'd3, d);
            chk("rnd_dbch", 32'(d), 32'h0FF);
            setreg(4'd7, 8'h00);
            chk("rnd_dtack", 32'(CDC_nIRQ), 32'd1);
        end

        // ---------------- random header FIFO traffic vs queue model
        m_ovf = 0;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                m = 8'($urandom); s = 8'($urandom); f = 8'($urandom);
                push_hdr(m, s, f);
                if (q.size() == DEPTH) begin void'(q.pop_front()); m_ovf = 1; end
                q.push_back({m, s, f});
            end else if (op == 2) begin
                getreg(4'd15, d);
                chk("rnd_stat3", 32'(d), (q.size() == 0) ? 32'h80 : 32'h00);
                if (q.size() != 0) void'(q.pop_front());
            end else begin
                getreg(4'd4, d);
                expb = (q.size() != 0) ? q[0][23:16] : 8'h00;
                chk("rnd_head_m", 32'(d), 32'(expb));
                hrd(1'b1, d);
                expb = (q.size() != 0) ? q[0][15:8] : 8'h00;
                chk("rnd_head_s", 32'(d), 32'(expb));
                hrd(1'b1, d);
                expb = (q.size() != 0) ? q[0][7:0] : 8'h00;
                chk("rnd_head_f", 32'(d), 32'(expb));
            end
        end
        chk("rnd_ovf", 32'(HDR_OVF), 32'(m_ovf));
        while (q.size() != 0) begin
            getreg(4'd15, d);
            chk("drain_stat3", 32'(d), 32'h00);
            void'(q.pop_front());
        end
        getreg(4'd15, d);
        chk("drained", 32'(d), 32'h80);

        // ---------------- overflow: 5 pushes into 4 entries
        for (int i = 1; i <= 5; i++) push_hdr(8'(i), 8'(8'h10 + i), 8'(8'h20 + i));
        chk("ovf_set", 32'(HDR_OVF), 32'd1);
        getreg(4'd4, d);
        chk("ovf_head_m", 32'(d), 32'h02);
        hrd(1'b1, d);
        chk("ovf_head_s", 32'(d), 32'h12);
        hrd(1'b1, d);
        chk("ovf_head_f", 32'(d), 32'h22);
        getreg(4'd13, d);
        chk("stat1_ovf", 32'(d), 32'h80);
        for (int i = 0; i < 4; i++) begin
            getreg(4'd15, d);
            chk($sformatf("ovf_pop%0d", i), 32'(d), 32'h00);
        end
        getreg(4'd15, d);
        chk("ovf_empty", 32'(d), 32'h80);

        // ---------------- SECTOR_READY edge coincident with STAT3 read
        setreg(4'd1, 8'h20);
        push_hdr(8'h09, 8'h19, 8'h29);
        hwr(1'b0, 8'h0F);
        RS = 1'b1; nRD = 1'b0; SECTOR_READY = 1'b1;
        tick();
        d = DOUT;
        chk("coinc_stat3", 32'(d), 32'h00);
        tick();
        nRD = 1'b1;
        tick(); tick();
        chk("coinc_nirq", 32'(CDC_nIRQ), 32'd0);
        getreg(4'd1, d);
        chk("coinc_deci", 32'(d), 32'h0DF);
        getreg(4'd15, d);
        chk("coinc_popped", 32'(d), 32'h80);
        tick(); tick();
        chk("deci_clr_nirq", 32'(CDC_nIRQ), 32'd1);
        SECTOR_READY = 1'b0;

        // ---------------- reset in the middle of a transfer
        start_xfer(5, 16'h2000, 8'h42);
        if (!XFER_REQ) chk("mid_xreq", 32'(XFER_REQ), 32'd1);
        XFER_ACK = 1'b1;
        tick();
        XFER_ACK = 1'b0;
        nRESET = 1'b0;
        #1;
        chk("mid_rst_xreq", 32'(XFER_REQ), 32'd0);
        chk("mid_rst_ovf", 32'(HDR_OVF), 32'd0);
        chk("mid_rst_nirq", 32'(CDC_nIRQ), 32'd1);
        tick();
        nRESET = 1'b1;
        repeat (4) tick();
        chk("post_rst_xreq", 32'(XFER_REQ), 32'd0);
        getreg(4'd1, d);
        chk("post_rst_ifstat", 32'(d), 32'h0FF);
        getreg(4'd2, d);
        chk("post_rst_dbcl", 32'(d), 32'h00);
        hrd(1'b1, d);
        chk("post_rst_dbch", 32'(d), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
